// File: rtl/mul_arb.sv
// ---------------------------------------------------------------------------
// mul_arb
//
// Round-robin arbiter and sequencer that shares one sequential 8x8 multiplier
// ("mul") among N requesters. A winner is picked in IDLE. Its operands are
// captured and driven to the multiplier, along with a one-cycle start. The
// operands are held while the multiplier runs. When the multiplier reports
// fin, the 17-bit product is returned to the winner with a one-cycle strobe.
//
// Optional feature macro: MUL_ARB_TIMEOUT_EN
//   Defined     : a watchdog counts WAIT cycles. When it reaches TMO without
//                 fin, the operation completes with rsp_err=1 and rsp_data=0.
//   Not defined : WAIT waits indefinitely and rsp_err is tied to 0.
//
// Parameters:
//   N    number of requesters (2..8)
//   TMO  watchdog limit in cycles (only meaningful with MUL_ARB_TIMEOUT_EN)
//
// Ports:
//   ck         in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   [N]    per-requester level request, held until ack
//   a_in       in   [8N]   operand A, requester i in bits [8i+7:8i]
//   b_in       in   [8N]   operand B, same packing
//   ack        out  [N]    one-hot pulse: operands captured
//   rsp_valid  out  [N]    one-hot pulse: result ready
//   rsp_data   out  [17]   product, valid with rsp_valid
//   rsp_err    out         watchdog timeout flag, qualified by rsp_valid
//   busy       out         high whenever the sequencer is not IDLE
//   mul_a      out  [8]    operand A to the multiplier
//   mul_b      out  [8]    operand B to the multiplier
//   mul_start  out         start pulse to the multiplier
//   mul_o      in   [17]   product from the multiplier
//   mul_fin    in          completion flag from the multiplier
// ---------------------------------------------------------------------------
module mul_arb #(
  parameter int N   = 4,
  parameter int TMO = 16
) (
  input  logic           ck,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] a_in,
  input  logic [8*N-1:0] b_in,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   rsp_valid,
  output logic [16:0]    rsp_data,
  output logic           rsp_err,
  output logic           busy,
  output logic [7:0]     mul_a,
  output logic [7:0]     mul_b,
  output logic           mul_start,
  input  logic [16:0]    mul_o,
  input  logic           mul_fin
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Catch illegal configurations at elaboration time.
  if (N < 2 || N > 8 || TMO < 1) begin : g_bad_param
    $error("mul_arb: N must be 2..8 and TMO must be positive");
  end

  state_t         state, state_nxt;
  logic [IW-1:0]  grant, grant_nxt;
  logic [IW-1:0]  ptr, ptr_nxt;
  logic [7:0]     mul_a_nxt, mul_b_nxt;
  logic [N-1:0]   ack_nxt, rsp_valid_nxt;
  logic [16:0]    rsp_data_nxt;
  logic           mul_start_nxt;
  logic           busy_nxt;

  logic           rr_found;
  logic [IW-1:0]  rr_idx;
  int             rr_cand;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0]  tmo_cnt, tmo_cnt_nxt;
  logic           rsp_err_q, rsp_err_nxt;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Round-robin search: the first requester at or after ptr, wrapping at N.
  // The wrap is done by subtraction so that N need not be a power of two.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = 0;
    for (int k = 0; k < N; k++) begin
      rr_cand = int'(ptr) + k;
      if (rr_cand >= N) rr_cand = rr_cand - N;
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = IW'(rr_cand);
      end
    end
  end

  // Next-state and next-output logic. Every output is registered from these
  // *_nxt values, so no input reaches an output combinationally. The ack and
  // start pulses are launched on the IDLE->START edge. rsp_valid is launched
  // on the WAIT->DONE edge, so each pulse is high during exactly the state
  // that owns it.
  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    ptr_nxt       = ptr;
    mul_a_nxt     = mul_a;
    mul_b_nxt     = mul_b;
    rsp_data_nxt  = rsp_data;
    ack_nxt       = '0;
    rsp_valid_nxt = '0;
    mul_start_nxt = 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
    tmo_cnt_nxt   = tmo_cnt;
    rsp_err_nxt   = rsp_err_q;
`endif

    case (state)
      IDLE: begin
        if (rr_found) begin
          grant_nxt       = rr_idx;
          mul_a_nxt       = a_in[8*rr_idx +: 8];
          mul_b_nxt       = b_in[8*rr_idx +: 8];
          ack_nxt[rr_idx] = 1'b1;
          mul_start_nxt   = 1'b1;
          state_nxt       = START;
        end
      end

      START: begin
        state_nxt = WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
        tmo_cnt_nxt = '0;
`endif
      end

      WAIT: begin
        // A fin in the expiry cycle still counts as a normal completion.
        if (mul_fin) begin
          rsp_data_nxt         = mul_o;
          rsp_valid_nxt[grant] = 1'b1;
          ptr_nxt              = (int'(grant) == N - 1) ? '0 : grant + 1'b1;
          state_nxt            = DONE;
`ifdef MUL_ARB_TIMEOUT_EN
          rsp_err_nxt          = 1'b0;
`endif
        end
`ifdef MUL_ARB_TIMEOUT_EN
        else if (tmo_cnt == CW'(TMO)) begin
          rsp_data_nxt         = '0;
          rsp_err_nxt          = 1'b1;
          rsp_valid_nxt[grant] = 1'b1;
          ptr_nxt              = (int'(grant) == N - 1) ? '0 : grant + 1'b1;
          state_nxt            = DONE;
        end
        else begin
          tmo_cnt_nxt = tmo_cnt + 1'b1;
        end
`endif
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State register and output flops. The multiplier itself has no reset, so
  // a reset here simply abandons any operation in flight. A late fin from
  // that operation is ignored because only WAIT looks at mul_fin.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      ack       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      mul_start <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      ptr       <= ptr_nxt;
      mul_a     <= mul_a_nxt;
      mul_b     <= mul_b_nxt;
      ack       <= ack_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
      mul_start <= mul_start_nxt;
      busy      <= busy_nxt;
    end
  end

`ifdef MUL_ARB_TIMEOUT_EN
  // Watchdog counter and error flag.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_cnt   <= tmo_cnt_nxt;
      rsp_err_q <= rsp_err_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mul_arb.sv
// ---------------------------------------------------------------------------
// tb_mul_arb
//
// Directed testbench for mul_arb (N=4, TMO=16). A small behavioural
// multiplier sits on the mul_* pins. It asserts fin nine cycles after it
// samples start. It can be told to hang, or to emit a stray fin.
// Build with MUL_ARB_TIMEOUT_EN defined to run the watchdog scenario.
// ---------------------------------------------------------------------------
module tb_mul_arb;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic           ck = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] a_in = '0;
  logic [8*N-1:0] b_in = '0;
  logic [N-1:0]   ack;
  logic [N-1:0]   rsp_valid;
  logic [16:0]    rsp_data;
  logic           rsp_err;
  logic           busy;
  logic [7:0]     mul_a;
  logic [7:0]     mul_b;
  logic           mul_start;
  logic [16:0]    mul_o;
  logic           mul_fin;

  int test_count = 0;
  int fail_count = 0;

  mul_arb #(.N(N), .TMO(TMO)) dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .ack       (ack),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_start (mul_start),
    .mul_o     (mul_o),
    .mul_fin   (mul_fin)
  );

  always #5 ck = ~ck;

  // Behavioural multiplier: latches operands on start and raises fin in the
  // ninth cycle after the start cycle. It has no reset.
  logic [3:0]  m_cnt = '0;
  logic [16:0] m_prod = '0;
  logic        hang = 1'b0;
  logic        force_fin = 1'b0;

  always @(posedge ck) begin
    if (mul_start) begin
      m_cnt  <= 4'd1;
      m_prod <= mul_a * mul_b;
    end else if (m_cnt == 4'd9) begin
      m_cnt <= 4'd0;
    end else if (m_cnt != 4'd0) begin
      m_cnt <= m_cnt + 4'd1;
    end
  end

  assign mul_fin = force_fin | (!hang && m_cnt == 4'd9);
  assign mul_o   = m_prod;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] a,
                               input logic [7:0] b);
    req[idx]          = 1'b1;
    a_in[8*idx +: 8]  = a;
    b_in[8*idx +: 8]  = b;
  endtask

  // One complete operation. req is raised at a negedge, so the following
  // posedge is the sampling cycle t. exp_lat is the cycle of rsp_valid
  // relative to t.
  task automatic runOne(input int idx, input logic [7:0] a, input logic [7:0] b,
                        input logic [16:0] exp_data, input logic exp_err,
                        input int exp_lat);
    int  lat;
    bit  seen;
    @(negedge ck);
    applyStimulus(idx, a, b);
    @(negedge ck);
    checkOutput("ack", 32'(ack), 32'(1 << idx));
    checkOutput("mul_start", 32'(mul_start), 32'd1);
    checkOutput("mul_a", 32'(mul_a), 32'(a));
    checkOutput("mul_b", 32'(mul_b), 32'(b));
    req = '0;
    lat  = 1;
    seen = 1'b0;
    while (lat < 40 && !seen) begin
      @(negedge ck);
      lat++;
      if (rsp_valid != '0) seen = 1'b1;
    end
    checkOutput("rsp_latency", 32'(lat), 32'(exp_lat));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(1 << idx));
    checkOutput("rsp_data", 32'(rsp_data), 32'(exp_data));
    checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
    checkOutput("mul_a_hold", 32'(mul_a), 32'(a));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  cyc;
    int  last_rsp;
    int  n_ack;
    int  n_rsp;
    bit  bad_valid;
    bit  bad_busy;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge ck);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mul_start", 32'(mul_start), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_mul_a", 32'(mul_a), 32'd0);
    rst_n = 1'b1;
    @(negedge ck);

    // Single request and operand corners.
    runOne(0, 8'h0C, 8'h0D, 17'h0009C, 1'b0, 11);
    runOne(3, 8'hFF, 8'hFF, 17'h0FE01, 1'b0, 11);
    runOne(1, 8'h00, 8'hFF, 17'h00000, 1'b0, 11);
    runOne(2, 8'h80, 8'h02, 17'h00100, 1'b0, 11);
    @(negedge ck);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of WAIT.
    @(negedge ck);
    applyStimulus(1, 8'h11, 8'h22);
    @(negedge ck);
    checkOutput("mw_ack", 32'(ack), 32'b0010);
    req = '0;
    repeat (4) @(negedge ck);
    checkOutput("mw_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mw_busy", 32'(busy), 32'd0);
    checkOutput("mw_mul_a", 32'(mul_a), 32'd0);
    checkOutput("mw_mul_b", 32'(mul_b), 32'd0);
    checkOutput("mw_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("mw_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge ck);
    rst_n = 1'b1;

    // The abandoned multiplier raises fin while the arbiter is IDLE. A forced
    // stray fin follows. Neither may produce a response.
    bad_valid = 1'b0;
    bad_busy  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ck);
      if (i == 6) force_fin = 1'b1;
      if (i == 7) force_fin = 1'b0;
      if (rsp_valid != '0) bad_valid = 1'b1;
      if (busy) bad_busy = 1'b1;
    end
    checkOutput("stray_fin_valid", 32'(bad_valid), 32'd0);
    checkOutput("stray_fin_busy", 32'(bad_busy), 32'd0);
    runOne(2, 8'h11, 8'h22, 17'h00242, 1'b0, 11);

    // Fairness: all four requesters held high from a fresh reset.
    rst_n = 1'b0;
    @(negedge ck);
    rst_n = 1'b1;
    @(negedge ck);
    for (int i = 0; i < N; i++) applyStimulus(i, 8'(i + 2), 8'(i + 3));
    cyc = 0;
    last_rsp = 0;
    n_ack = 0;
    n_rsp = 0;
    while (n_rsp < 5 && cyc < 80) begin
      @(negedge ck);
      cyc++;
      if (ack != '0) begin
        checkOutput("fair_ack", 32'(ack), 32'(1 << (n_ack % N)));
        n_ack++;
      end
      if (rsp_valid != '0) begin
        checkOutput("fair_rsp_valid", 32'(rsp_valid), 32'(1 << (n_rsp % N)));
        checkOutput("fair_rsp_data", 32'(rsp_data),
                    32'(((n_rsp % N) + 2) * ((n_rsp % N) + 3)));
        if (n_rsp > 0) checkOutput("fair_interval", 32'(cyc - last_rsp), 32'd12);
        last_rsp = cyc;
        n_rsp++;
      end
    end
    checkOutput("fair_count", 32'(n_rsp), 32'd5);
    req = '0;
    repeat (14) @(negedge ck);
    checkOutput("fair_idle", 32'(busy), 32'd0);

`ifdef MUL_ARB_TIMEOUT_EN
    // Watchdog: the multiplier never finishes.
    hang = 1'b1;
    runOne(0, 8'h05, 8'h07, 17'h00000, 1'b1, 19);
    hang = 1'b0;
    @(negedge ck);
    runOne(1, 8'h05, 8'h07, 17'h00023, 1'b0, 11);
`else
    // Without the watchdog a hung multiplier keeps the arbiter busy.
    hang = 1'b1;
    @(negedge ck);
    applyStimulus(0, 8'h05, 8'h07);
    @(negedge ck);
    req = '0;
    bad_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ck);
      if (rsp_valid != '0) bad_valid = 1'b1;
    end
    checkOutput("hang_busy", 32'(busy), 32'd1);
    checkOutput("hang_no_valid", 32'(bad_valid), 32'd0);
    rst_n = 1'b0;
    hang  = 1'b0;
    @(negedge ck);
    rst_n = 1'b1;
    runOne(1, 8'h05, 8'h07, 17'h00023, 1'b0, 11);
`endif

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
